// File: rtl/rs232_rx_fifo.sv
// RS232 receiver: synchronised RxD, programmable bit divisor, optional parity,
// 3-sample majority vote at mid-bit, and a small receive FIFO with per-byte error flags.
module rs232_rx_fifo #(
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RxD,
  input  logic [DIV_W-1:0]     divisor,
  input  logic                 par_en,
  input  logic                 par_odd,
  input  logic                 done,
  input  logic                 err_clr,
  output logic                 rdy,
  output logic [DATA_BITS-1:0] data,
  output logic                 frame_err,
  output logic                 par_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int ENT_W = DATA_BITS + 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx_d_reg;
  logic                   rx_s;
  logic                   fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= '1;
      rx_d_reg <= 1'b1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], RxD};
      rx_d_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign rx_s = sync_reg[SYNC_STAGES-1];
  assign fall = rx_d_reg & ~rx_s;

  state_t                state_reg, state_next;
  logic [DIV_W-1:0]      tick_reg, tick_next, div_reg, div_next, mid;
  logic                  par_en_reg, par_en_next, par_odd_reg, par_odd_next;
  logic [BIT_W-1:0]      bit_reg, bit_next;
  logic [DATA_BITS-1:0]  shift_reg, shift_next;
  logic                  s0_reg, s0_next, s1_reg, s1_next;
  logic                  perr_reg, perr_next;
  logic                  at_s0, at_s1, at_vote, at_end, vote;
  logic                  push;
  logic [ENT_W-1:0]      push_ent;

  assign mid     = div_reg >> 1;
  assign at_s0   = (tick_reg == mid - DIV_W'(1));
  assign at_s1   = (tick_reg == mid);
  assign at_vote = (tick_reg == mid + DIV_W'(1));
  assign at_end  = (tick_reg == div_reg - DIV_W'(1));
  // Third sample is the live synchronised input, so the vote settles in the mid+1 cycle.
  assign vote    = (s0_reg & s1_reg) | (s0_reg & rx_s) | (s1_reg & rx_s);
  assign push_ent = {shift_reg, ~vote, perr_reg};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      tick_reg    <= '0;
      div_reg     <= DIV_W'(4);
      par_en_reg  <= 1'b0;
      par_odd_reg <= 1'b0;
      bit_reg     <= '0;
      shift_reg   <= '0;
      s0_reg      <= 1'b1;
      s1_reg      <= 1'b1;
      perr_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tick_reg    <= tick_next;
      div_reg     <= div_next;
      par_en_reg  <= par_en_next;
      par_odd_reg <= par_odd_next;
      bit_reg     <= bit_next;
      shift_reg   <= shift_next;
      s0_reg      <= s0_next;
      s1_reg      <= s1_next;
      perr_reg    <= perr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    tick_next    = at_end ? '0 : tick_reg + DIV_W'(1);
    div_next     = div_reg;
    par_en_next  = par_en_reg;
    par_odd_next = par_odd_reg;
    bit_next     = bit_reg;
    shift_next   = shift_reg;
    s0_next      = at_s0 ? rx_s : s0_reg;
    s1_next      = at_s1 ? rx_s : s1_reg;
    perr_next    = perr_reg;
    push         = 1'b0;
    case (state_reg)
      IDLE: begin
        tick_next = '0;
        if (fall) begin
          state_next   = START;
          div_next     = (divisor < DIV_W'(4)) ? DIV_W'(4) : divisor;
          par_en_next  = par_en;
          par_odd_next = par_odd;
          bit_next     = '0;
          perr_next    = 1'b0;
        end
      end
      START: begin
        if (at_vote && vote) state_next = IDLE;
        else if (at_end)     state_next = DATA;
      end
      DATA: begin
        if (at_vote) shift_next = {vote, shift_reg[DATA_BITS-1:1]};
        if (at_end) begin
          if (bit_reg == BIT_W'(DATA_BITS - 1))
            state_next = par_en_reg ? PARITY : STOP;
          else
            bit_next = bit_reg + BIT_W'(1);
        end
      end
      PARITY: begin
        if (at_vote) perr_next = (^shift_reg) ^ vote ^ par_odd_reg;
        if (at_end)  state_next = STOP;
      end
      STOP: begin
        if (at_vote) begin
          push       = 1'b1;
          state_next = vote ? IDLE : BRK;
        end
      end
      BRK: begin
        tick_next = '0;
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg != IDLE);

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
  logic [PTR_W:0]   count_reg, count_next;
  logic [ENT_W-1:0] head_reg, head_next;
  logic             ovr_reg, ovr_next;
  logic             full, pop_ok, push_ok;

  assign full    = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
  assign pop_ok  = done && (count_reg != '0);
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_next = push_ok ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
    rd_ptr_next = pop_ok  ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
    count_next  = count_reg;
    if (push_ok && !pop_ok) count_next = count_reg + (PTR_W+1)'(1);
    if (!push_ok && pop_ok) count_next = count_reg - (PTR_W+1)'(1);
    // A push landing in the new head slot is not in mem yet, so forward it.
    head_next = head_reg;
    if (push_ok && (wr_ptr_reg == rd_ptr_next)) head_next = push_ent;
    else if (count_next != '0)                  head_next = mem[rd_ptr_next];
    ovr_next = ovr_reg;
    if (push && !push_ok) ovr_next = 1'b1;
    else if (err_clr)     ovr_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_ent;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
      ovr_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
      ovr_reg    <= ovr_next;
    end
  end

  assign rdy       = (count_reg != '0);
  assign data      = head_reg[ENT_W-1:2];
  assign frame_err = head_reg[1];
  assign par_err   = head_reg[0];
  assign overrun   = ovr_reg;
endmodule

// File: tb/tb_rs232_rx_fifo.sv
// Bench for rs232_rx_fifo: frames are driven bit by bit and a queue model of the FIFO
// predicts the head entry, rdy, overrun and busy whenever the line is quiet.
module tb_rs232_rx_fifo;
  logic        clk = 1'b0;
  logic        rst;
  logic        RxD;
  logic [15:0] divisor;
  logic        par_en, par_odd, done, err_clr;
  logic        rdy, frame_err, par_err, overrun, busy;
  logic [7:0]  data;

  rs232_rx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .DIV_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .RxD(RxD), .divisor(divisor), .par_en(par_en),
    .par_odd(par_odd), .done(done), .err_clr(err_clr), .rdy(rdy), .data(data),
    .frame_err(frame_err), .par_err(par_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0, n_pass = 0;
  int          cyc = 0, start_cyc = 0, rise_cyc = -1;
  logic        rdy_q = 1'b0;
  bit          settled = 1'b0;
  logic [9:0]  exp_q[$];
  logic [9:0]  last_head = '0;
  logic        exp_ovr = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rdy && !rdy_q) rise_cyc = cyc;
    rdy_q = rdy;
  end

  // Whenever no frame is in flight, every output must match the model.
  always @(negedge clk) begin
    if (settled && rst) begin
      check("rdy", 32'(rdy), 32'(exp_q.size() != 0));
      check("head", 32'({data, frame_err, par_err}),
            32'((exp_q.size() != 0) ? exp_q[0] : last_head));
      check("overrun", 32'(overrun), 32'(exp_ovr));
      check("busy_idle", 32'(busy), 32'(0));
    end
  end

  task automatic model_push(input logic [9:0] e);
    if (exp_q.size() < 4) exp_q.push_back(e);
    else exp_ovr = 1'b1;
  endtask

  task automatic model_pop();
    if (exp_q.size() != 0) last_head = exp_q.pop_front();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pop();
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    model_pop();
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    exp_ovr = 1'b0;
  endtask

  task automatic drive_bit(input logic v, input int len, input int glitch_at, input int done_at);
    for (int c = 0; c < len; c++) begin
      RxD  = (c == glitch_at) ? ~v : v;
      done = (c == done_at);
      @(posedge clk); #1;
    end
    done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input int div, input bit pen, input bit podd,
                            input bit pbit, input bit stop_ok, input int gl_bit,
                            input bit pop_at_push, input bit scramble);
    int eff, mid;
    logic pe;
    eff = (div < 4) ? 4 : div;
    mid = eff / 2;
    settled = 1'b0;
    divisor = 16'(div);
    par_en  = pen;
    par_odd = podd;
    start_cyc = cyc;
    drive_bit(1'b0, eff, (gl_bit == 0) ? mid + 1 : -1, -1);
    if (scramble) begin
      divisor = 16'($urandom);
      par_en  = 1'($urandom);
      par_odd = 1'($urandom);
    end
    for (int b = 0; b < 8; b++) drive_bit(d[b], eff, (gl_bit == b + 1) ? mid + 1 : -1, -1);
    if (pen) drive_bit(pbit, eff, -1, -1);
    if (stop_ok) begin
      drive_bit(1'b1, eff, -1, pop_at_push ? mid + 4 : -1);
    end else begin
      drive_bit(1'b0, 3 * eff, -1, -1);
      check("brk_busy", 32'(busy), 32'(1));
      RxD = 1'b1;
    end
    idle(6);
    if (pop_at_push) model_pop();
    pe = pen && ((($countones(d) + int'(pbit) + int'(podd)) % 2) != 0);
    model_push({d, ~stop_ok, pe});
    settled = 1'b1;
  endtask

  initial begin
    int   dv;
    logic [7:0] d;
    bit   pen, podd, pbit, sok;

    rst = 1'b0; RxD = 1'b1; divisor = 16'd347; par_en = 1'b0; par_odd = 1'b0;
    done = 1'b0; err_clr = 1'b0;
    idle(3);
    check("reset_rdy", 32'(rdy), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_ovr", 32'(overrun), 32'(0));
    check("reset_head", 32'({data, frame_err, par_err}), 32'(0));
    rst = 1'b1;
    idle(3);
    settled = 1'b1;

    // 0x55 at 347: start edge -> 3 sync/detect cycles, 9 bits, vote at tick 174, +1 to become visible.
    send_frame(8'h55, 347, 0, 0, 0, 1, -1, 0, 0);
    check("t1_latency", 32'(rise_cyc - start_cyc), 32'(3 + 9 * 347 + 174 + 1));
    check("t1_entry", 32'({data, frame_err, par_err}), 32'({8'h55, 2'b00}));
    pop();
    check("t1_rdy_after_done", 32'(rdy), 32'(0));
    pop();

    // 0xA3 has four ones.
    send_frame(8'hA3, 40, 1, 0, 0, 1, -1, 0, 0);
    check("even_p0", 32'({data, par_err}), 32'({8'hA3, 1'b0}));
    pop();
    send_frame(8'hA3, 40, 1, 0, 1, 1, -1, 0, 0);
    check("even_p1", 32'({data, par_err}), 32'({8'hA3, 1'b1}));
    pop();
    send_frame(8'hA3, 40, 1, 1, 0, 1, -1, 0, 0);
    check("odd_p0", 32'({data, par_err}), 32'({8'hA3, 1'b1}));
    pop();
    send_frame(8'hA3, 40, 1, 1, 1, 1, -1, 0, 0);
    check("odd_p1", 32'({data, par_err}), 32'({8'hA3, 1'b0}));
    pop();

    settled = 1'b0;
    divisor = 16'd347; par_en = 1'b0;
    RxD = 1'b0;
    idle(100);
    RxD = 1'b1;
    check("false_start_busy", 32'(busy), 32'(1));
    idle(80);
    check("false_start_idle", 32'(busy), 32'(0));
    check("false_start_rdy", 32'(rdy), 32'(0));
    settled = 1'b1;
    send_frame(8'h3C, 347, 0, 0, 0, 1, -1, 0, 0);
    check("after_false", 32'({data, frame_err, par_err}), 32'({8'h3C, 2'b00}));
    pop();

    send_frame(8'h00, 40, 0, 0, 0, 0, -1, 0, 0);
    send_frame(8'h7E, 40, 0, 0, 0, 1, -1, 0, 0);
    check("brk_first", 32'({data, frame_err}), 32'({8'h00, 1'b1}));
    pop();
    check("brk_second", 32'({data, frame_err}), 32'({8'h7E, 1'b0}));
    pop();

    for (int i = 1; i <= 5; i++) send_frame(8'(i), 40, 0, 0, 0, 1, -1, 0, 0);
    check("ovr_set", 32'(overrun), 32'(1));
    check("ovr_head", 32'(data), 32'(8'h01));
    clear_err();
    check("ovr_clr", 32'(overrun), 32'(0));
    send_frame(8'h06, 40, 0, 0, 0, 1, -1, 1, 0);
    check("full_push_pop_ovr", 32'(overrun), 32'(0));
    check("full_push_pop_head", 32'(data), 32'(8'h02));
    repeat (5) pop();
    check("drained_hold", 32'(data), 32'(8'h06));

    // A divisor below 4 runs at 4 clocks per bit.
    send_frame(8'h96, 1, 0, 0, 0, 1, -1, 0, 0);
    check("div_floor", 32'(data), 32'(8'h96));
    pop();

    send_frame(8'h55, 2083, 0, 0, 0, 1, 1, 0, 0);
    check("glitch", 32'({data, frame_err}), 32'({8'h55, 1'b0}));

    settled = 1'b0;
    divisor = 16'd40;
    drive_bit(1'b0, 40, -1, -1);
    drive_bit(1'b1, 40, -1, -1);
    drive_bit(1'b0, 20, -1, -1);
    rst = 1'b0;
    #1;
    check("rst_rdy", 32'(rdy), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    exp_q.delete();
    last_head = '0;
    exp_ovr = 1'b0;
    RxD = 1'b1;
    idle(2);
    rst = 1'b1;
    idle(2);
    settled = 1'b1;
    idle(100);

    for (int i = 0; i < 30; i++) begin
      dv   = $urandom_range(6, 48);
      d    = 8'($urandom);
      pen  = 1'($urandom_range(0, 1));
      podd = 1'($urandom_range(0, 1));
      pbit = 1'((($countones(d) + int'(podd)) % 2) ^ ($urandom_range(0, 3) == 0));
      sok  = ($urandom_range(0, 7) != 0);
      send_frame(d, dv, pen, podd, pbit, sok, -1, 0, 1);
      repeat ($urandom_range(0, 2)) pop();
      if ($urandom_range(0, 5) == 0) clear_err();
      idle($urandom_range(1, 8));
    end
    repeat (5) pop();
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
